// File: rtl/vgafb_burst_fetch.sv
// Framebuffer fetch: 4x64 FML read bursts into a FWFT FIFO, unpacked to RGB565 pixels.
// Optional underrun statistics counter enabled by defining VGAFB_BURST_FETCH_STATS_EN.
module vgafb_burst_fetch #(
    parameter int fml_depth = 26,
    parameter int fifo_aw   = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 vga_rst,
    input  logic [17:0]          nbursts,
    input  logic [fml_depth-1:0] baseaddress,
    output logic                 baseaddress_ack,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    input  logic                 fml_ack,
    input  logic [63:0]          fml_di,
    output logic                 pixel_valid,
    output logic [15:0]          pixel,
    input  logic                 pixel_ack,
    output logic [15:0]          underrun_count
);
    localparam int DEPTH = 1 << fifo_aw;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_DATA, S_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [fml_depth-1:0] fml_adr_q, fml_adr_d;
    logic                 fml_stb_q, fml_stb_d;
    logic                 base_ack_q, base_ack_d;
    logic [17:0]          burst_q, burst_d;
    logic [1:0]           beat_q, beat_d;
    logic [fifo_aw-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [fifo_aw:0]     count_q, count_d;
    logic [1:0]           sub_q, sub_d;
    logic [63:0]          mem_q [DEPTH];

    logic                 wr_en, pop, frame_end;
    logic [fifo_aw:0]     free_slots;
    logic [fml_depth-1:0] base_aligned;
    logic [63:0]          head;

    assign base_aligned = baseaddress & {{(fml_depth-5){1'b1}}, 5'b0};
    // WAIT is only entered once every beat of the previous burst is stored, so nothing is owed there.
    assign free_slots   = (fifo_aw+1)'(DEPTH) - count_q;
    assign frame_end    = (19'(burst_q) + 19'd1) >= 19'(nbursts);
    assign pixel_valid  = (count_q != '0);
    assign wr_en        = (state_q == S_DATA) && !vga_rst;
    assign pop          = pixel_valid && pixel_ack && (sub_q == 2'd3);
    assign head         = mem_q[rd_ptr_q];

    assign fml_adr         = fml_adr_q;
    assign fml_stb         = fml_stb_q;
    assign baseaddress_ack = base_ack_q;

    always_comb begin
        state_d    = state_q;
        fml_adr_d  = fml_adr_q;
        fml_stb_d  = fml_stb_q;
        base_ack_d = 1'b0;
        burst_d    = burst_q;
        beat_d     = beat_q;
        case (state_q)
            S_IDLE: begin
                if (!vga_rst && nbursts != '0) begin
                    fml_adr_d  = base_aligned;
                    base_ack_d = 1'b1;
                    burst_d    = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vga_rst) begin
                    state_d = S_IDLE;
                end else if (free_slots >= (fifo_aw+1)'(4)) begin
                    fml_stb_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted burst must still be drained even if a restart arrives with the ack.
                if (fml_ack) begin
                    fml_stb_d = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = vga_rst ? S_DRAIN : S_DATA;
                end else if (vga_rst) begin
                    fml_stb_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_DATA: begin
                beat_d = beat_q + 2'd1;
                if (vga_rst) begin
                    state_d = (beat_q == 2'd3) ? S_IDLE : S_DRAIN;
                end else if (beat_q == 2'd3) begin
                    state_d = S_WAIT;
                    if (frame_end) begin
                        burst_d    = '0;
                        fml_adr_d  = base_aligned;
                        base_ack_d = 1'b1;
                        if (nbursts == '0) begin
                            base_ack_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        burst_d   = burst_q + 18'd1;
                        fml_adr_d = fml_adr_q + fml_depth'(32);
                    end
                end
            end
            S_DRAIN: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (vga_rst) burst_d = '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sub_d    = sub_q;
        if (vga_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sub_d    = '0;
        end else begin
            if (pixel_valid && pixel_ack) sub_d = sub_q + 2'd1;
            if (wr_en) wr_ptr_d = wr_ptr_q + fifo_aw'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + fifo_aw'(1);
            count_d = count_q + (fifo_aw+1)'(wr_en) - (fifo_aw+1)'(pop);
        end
    end

    // Big-endian unpack: the most significant halfword is shown first.
    always_comb begin
        pixel = head[63:48];
        case (sub_q)
            2'd0:    pixel = head[63:48];
            2'd1:    pixel = head[47:32];
            2'd2:    pixel = head[31:16];
            default: pixel = head[15:0];
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            fml_adr_q  <= '0;
            fml_stb_q  <= 1'b0;
            base_ack_q <= 1'b0;
            burst_q    <= '0;
            beat_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sub_q      <= '0;
        end else begin
            state_q    <= state_d;
            fml_adr_q  <= fml_adr_d;
            fml_stb_q  <= fml_stb_d;
            base_ack_q <= base_ack_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sub_q      <= sub_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= fml_di;
    end

    fifo_no_overflow: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        !(wr_en && (count_q == (fifo_aw+1)'(DEPTH)) && !pop));

`ifdef VGAFB_BURST_FETCH_STATS_EN
    logic        written_q, written_d;
    logic [15:0] underrun_q, underrun_d;

    always_comb begin
        written_d  = written_q;
        underrun_d = underrun_q;
        if (vga_rst) begin
            written_d  = 1'b0;
            underrun_d = '0;
        end else begin
            if (wr_en) written_d = 1'b1;
            if (!pixel_valid && written_q && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            written_q  <= 1'b0;
            underrun_q <= '0;
        end else begin
            written_q  <= written_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun_count = underrun_q;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_vgafb_burst_fetch.sv
// Directed scoreboard bench for vgafb_burst_fetch; the bench acts as FML slave and pixel consumer.
module tb_vgafb_burst_fetch;
    localparam int FD = 26;
    localparam int AW = 4;
`ifdef VGAFB_BURST_FETCH_STATS_EN
    localparam logic [15:0] EXP_UNDERRUN = 16'd10;
`else
    localparam logic [15:0] EXP_UNDERRUN = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vga_rst = 1'b1;
    logic [17:0]   nbursts = 18'd3;
    logic [FD-1:0] baseaddress = 26'h1000;
    logic          base_ack;
    logic [FD-1:0] fml_adr;
    logic          fml_stb;
    logic          fml_ack = 1'b0;
    logic [63:0]   fml_di = '0;
    logic          pixel_valid;
    logic [15:0]   pixel;
    logic          pixel_ack = 1'b0;
    logic [15:0]   underrun_count;

    int checks = 0;
    int failures = 0;
    int ack_pulses = 0;
    int acks_left = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    vgafb_burst_fetch #(.fml_depth(FD), .fifo_aw(AW)) dut (
        .sys_clk        (clk),
        .sys_rst_n      (rst_n),
        .vga_rst        (vga_rst),
        .nbursts        (nbursts),
        .baseaddress    (baseaddress),
        .baseaddress_ack(base_ack),
        .fml_adr        (fml_adr),
        .fml_stb        (fml_stb),
        .fml_ack        (fml_ack),
        .fml_di         (fml_di),
        .pixel_valid    (pixel_valid),
        .pixel          (pixel),
        .pixel_ack      (pixel_ack),
        .underrun_count (underrun_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] b);
        return {b, b + 16'd1, b + 16'd2, b + 16'd3};
    endfunction

    task automatic push4(input logic [63:0] w);
        exp_q.push_back(w[63:48]);
        exp_q.push_back(w[47:32]);
        exp_q.push_back(w[31:16]);
        exp_q.push_back(w[15:0]);
    endtask

    // One clock: consumer acts before the edge, bookkeeping follows it.
    task automatic tick();
        logic [15:0] exp_pix;
        pixel_ack = 1'b0;
        chk("pixel_valid", 64'(pixel_valid), 64'(exp_q.size() != 0));
        if (!vga_rst && acks_left > 0 && exp_q.size() != 0) begin
            pixel_ack = 1'b1;
            exp_pix = exp_q.pop_front();
            chk("pixel", 64'(pixel), 64'(exp_pix));
            acks_left--;
        end
        @(posedge clk);
        #1;
        pixel_ack = 1'b0;
        if (vga_rst) exp_q.delete();
        if (base_ack === 1'b1) ack_pulses++;
    endtask

    task automatic fml_burst(input string tag, input logic [FD-1:0] exp_adr, input int delay,
                             input logic [63:0] w0, input logic [63:0] w1,
                             input logic [63:0] w2, input logic [63:0] w3, input bit discard);
        logic [63:0] w [4];
        int n;
        w = '{w0, w1, w2, w3};
        n = 0;
        while (fml_stb !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_stb"}, 64'(fml_stb), 64'd1);
        chk({tag, "_adr"}, 64'(fml_adr), 64'(exp_adr));
        if (fml_stb !== 1'b1) return;
        for (int i = 0; i < delay; i++) tick();
        chk({tag, "_hold"}, 64'({fml_stb, fml_adr}), 64'({1'b1, exp_adr}));
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        chk({tag, "_stb_drop"}, 64'(fml_stb), 64'd0);
        for (int b = 0; b < 4; b++) begin
            fml_di = w[b];
            if (discard) vga_rst = (b == 0);
            tick();
            if (!discard) push4(w[b]);
        end
        vga_rst = 1'b0;
        fml_di = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst_stb", 64'(fml_stb), 64'd0);
        chk("rst_adr", 64'(fml_adr), 64'd0);
        chk("rst_base_ack", 64'(base_ack), 64'd0);
        chk("rst_valid", 64'(pixel_valid), 64'd0);
        chk("rst_underrun", 64'(underrun_count), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame of 3 bursts, consumer always acks, unpack order on first word
        acks_left = 1_000_000;
        ack_pulses = 0;
        vga_rst = 1'b0;
        tick();
        chk("t1_base_ack", 64'(base_ack), 64'd1);
        chk("t1_adr_latch", 64'(fml_adr), 64'h1000);
        fml_burst("t1_b0", 26'h1000, 2, 64'h1111_2222_3333_4444, mk(16'h0100), mk(16'h0104), mk(16'h0108), 1'b0);
        fml_burst("t1_b1", 26'h1020, 2, mk(16'h0200), mk(16'h0204), mk(16'h0208), mk(16'h020c), 1'b0);
        chk("t1_pulses_mid", 64'(ack_pulses), 64'd1);
        fml_burst("t1_b2", 26'h1040, 2, mk(16'h0300), mk(16'h0304), mk(16'h0308), mk(16'h030c), 1'b0);
        chk("t1_pulses_end", 64'(ack_pulses), 64'd2);
        fml_burst("t1_b3", 26'h1000, 2, mk(16'h0400), mk(16'h0404), mk(16'h0408), mk(16'h040c), 1'b0);
        chk("t1_pulses_wrap", 64'(ack_pulses), 64'd2);
        drain("t1_drain");
        chk("t1_next_adr", 64'({fml_stb, fml_adr}), 64'({1'b1, 26'h1020}));
        vga_rst = 1'b1;
        tick();
        chk("t1_rst_in_req", 64'(fml_stb), 64'd0);
        tick();

        // Backpressure: no consumer, FIFO fills with exactly 4 bursts
        acks_left = 0;
        baseaddress = 26'h2000;
        nbursts = 18'd100;
        vga_rst = 1'b0;
        for (int k = 0; k < 4; k++)
            fml_burst("t2_fill", FD'(26'h2000 + 32 * k), 0, mk(16'(16'h3000 + 16 * k)), mk(16'(16'h3004 + 16 * k)),
                      mk(16'(16'h3008 + 16 * k)), mk(16'(16'h300c + 16 * k)), 1'b0);
        n = 0;
        repeat (40) begin tick(); if (fml_stb === 1'b1) n++; end
        chk("t2_full_no_req", 64'(n), 64'd0);
        acks_left = 4;
        n = 0;
        repeat (30) begin tick(); if (fml_stb === 1'b1) n++; end
        chk("t2_one_free_no_req", 64'(n), 64'd0);
        chk("t2_q_after4", 64'(exp_q.size()), 64'd60);
        acks_left = 12;
        fml_burst("t2_b4", 26'h2080, 0, mk(16'h3100), mk(16'h3104), mk(16'h3108), mk(16'h310c), 1'b0);
        n = 0;
        repeat (40) begin tick(); if (fml_stb === 1'b1) n++; end
        chk("t2_refull_no_req", 64'(n), 64'd0);
        chk("t2_q_full", 64'(exp_q.size()), 64'd64);
        vga_rst = 1'b1;
        tick();
        chk("t2_rst_valid", 64'(pixel_valid), 64'd0);
        tick();

        // vga_rst in the cycle after fml_ack discards the whole burst
        acks_left = 1_000_000;
        baseaddress = 26'h3000;
        nbursts = 18'd2;
        ack_pulses = 0;
        vga_rst = 1'b0;
        fml_burst("t3_b0", 26'h3000, 1, mk(16'h5000), mk(16'h5004), mk(16'h5008), mk(16'h500c), 1'b1);
        chk("t3_pulses_discard", 64'(ack_pulses), 64'd1);
        chk("t3_valid_discard", 64'(pixel_valid), 64'd0);
        fml_burst("t3_b1", 26'h3000, 0, mk(16'h5100), mk(16'h5104), mk(16'h5108), mk(16'h510c), 1'b0);
        chk("t3_pulses_restart", 64'(ack_pulses), 64'd2);
        drain("t3_drain");
        vga_rst = 1'b1;
        repeat (2) tick();

        // nbursts=0 stays idle, then nbursts=1 repeats one burst; low address bits ignored
        nbursts = 18'd0;
        baseaddress = 26'h4017;
        ack_pulses = 0;
        vga_rst = 1'b0;
        n = 0;
        repeat (1000) begin tick(); if (fml_stb === 1'b1) n++; end
        chk("t4_no_req", 64'(n), 64'd0);
        chk("t4_no_pulse", 64'(ack_pulses), 64'd0);
        nbursts = 18'd1;
        for (int k = 0; k < 3; k++)
            fml_burst("t4_rep", 26'h4000, 1, mk(16'(16'h6000 + 16 * k)), mk(16'(16'h6004 + 16 * k)),
                      mk(16'(16'h6008 + 16 * k)), mk(16'(16'h600c + 16 * k)), 1'b0);
        chk("t4_pulses", 64'(ack_pulses), 64'd4);
        drain("t4_drain");
        vga_rst = 1'b1;
        repeat (2) tick();

        // Underrun statistics: 10 starved cycles after the first data drains
        chk("t5_underrun_clr", 64'(underrun_count), 64'd0);
        baseaddress = 26'h5000;
        nbursts = 18'd2;
        vga_rst = 1'b0;
        fml_burst("t5_b0", 26'h5000, 0, mk(16'h7000), mk(16'h7004), mk(16'h7008), mk(16'h700c), 1'b0);
        drain("t5_drain");
        repeat (10) tick();
        chk("t5_underrun", 64'(underrun_count), 64'(EXP_UNDERRUN));
        vga_rst = 1'b1;
        tick();
        chk("t5_underrun_rst", 64'(underrun_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
